result_bus_arbiter: RTL and testbench
=====================================

Name: result_bus_arbiter

Overview:
- Shares the single result/update broadcast bus between UNITS execution-unit wrappers (add/sub, logical, multiply, ...).
- Each unit presents a ready-valid result carrying rs_id, destination GPR address, 32-bit result and cr0_xer.
- The arbiter grants one unit per cycle using a round-robin scheme and captures the winner in one output register.
- It drives the broadcast consumed by the reservation-station update ports and the writeback/commit stage.

Parameters:
- UNITS, 4, number of requesting execution units (2..8).
- RS_ID_WIDTH, 5, width of reservation-station ids.
- PTR_WIDTH, $clog2(UNITS), width of the round-robin pointer (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- flush  in  1  synchronous squash of the output register.
- unit_valid  in  [UNITS]  result valid per unit.
- unit_ready  out  [UNITS]  result accepted per unit (one-hot or zero).
- unit_rs_id  in  [UNITS][0:RS_ID_WIDTH-1]  producing rs_id per unit.
- unit_reg_addr  in  [UNITS][0:4]  destination GPR per unit.
- unit_result  in  [UNITS][0:31]  result value per unit.
- unit_cr0_xer  in  [UNITS] cond_exception_t  condition/exception info per unit.
- bus_valid  out  1  broadcast valid.
- bus_ready  in  1  downstream accepts broadcast.
- bus_rs_id  out  [0:RS_ID_WIDTH-1]  broadcast rs_id.
- bus_reg_addr  out  [0:4]  broadcast destination GPR.
- bus_result  out  [0:31]  broadcast value.
- bus_cr0_xer  out  cond_exception_t  broadcast condition info.
- bus_unit  out  [0:PTR_WIDTH-1]  index of the unit that produced the current broadcast.

Behaviour:
- Reset (rst=0, async): bus_valid=0, bus_rs_id/bus_reg_addr/bus_result/bus_unit=0, bus_cr0_xer all-zero, rr_ptr=0. unit_ready=0 while in reset.
- load_en = !bus_valid || bus_ready. Full throughput: one result per cycle when bus_ready is held 1.
- Grant (combinational):
  - When load_en=1, select the first i with unit_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo UNITS.
  - unit_ready[i]=1 for that unit only; all other unit_ready=0.
  - When load_en=0, or no unit is valid, all unit_ready=0.
- unit_ready must not depend combinationally on unit_valid of the same unit except through selection. Units must hold data stable while valid && !ready.
- On a grant edge:
  - Output register loads the granted unit's fields; bus_valid=1, bus_unit=i.
  - rr_ptr <= (i+1) mod UNITS; wrap from UNITS-1 to 0.
- Latency: one cycle from unit handshake to bus_valid.
- Broadcast handshake:
  - A transfer completes on bus_valid && bus_ready.
  - If there is no new grant on the same edge, bus_valid <= 0.
  - Back-to-back grant and consume on the same edge is required: the register reloads.
- Stall: bus_valid && !bus_ready holds all bus_* stable, issues no grants and leaves rr_ptr unchanged.
- flush=1 (sync):
  - bus_valid <= 0.
  - No grant that cycle; unit_ready all 0.
  - rr_ptr unchanged.
  - Flush has priority over bus_ready and over any pending grant.
- No valid requests: rr_ptr unchanged.
- A single requester gets a grant every cycle when bus_ready is held 1.
- Starvation bound: a continuously valid unit is granted within UNITS grants.
- Async reset mid-transfer: bus_valid drops immediately and the in-flight result is discarded. Upstream units are reset by the same rst.

Decomposition:
- ppc_types holds cond_exception_t (existing).
- Add to ppc_types a struct result_bus_t {rs_id, reg_addr, result, cr0_xer}; RS_ID_WIDTH is fixed by the package default for the struct.
- Sub-module rr_priority_select (parameter N): inputs request vector and pointer; outputs one-hot grant and index. Purely combinational.
- The arbiter owns the pointer and the output register.

Test Plan:
- Reset: hold rst=0 with all unit_valid=1 -> bus_valid=0, unit_ready=0, bus_result=0. Release rst -> next edge grants unit 0, bus_unit=0, rr_ptr=1.
- Round robin:
  - Setup: UNITS=4, all valid, bus_ready=1, unit_result[i]=32'h100+i.
  - Required: bus_result sequence 100,101,102,103,100 on consecutive cycles; exactly one unit_ready per cycle.
- Sparse wrap:
  - Setup: rr_ptr=3, only units 1 and 3 valid.
  - Required: grant unit 3 first, then unit 1 (ptr wraps 0 -> 1), then unit 3.
- Stall:
  - Stimulus: bus_valid=1 with rs_id=5'd7, bus_ready=0 for 3 cycles while unit 2 is valid.
  - Required: bus_* stable at 7, unit_ready=0. On bus_ready=1, unit 2 is loaded on the same edge with no bubble.
- Flush: flush=1 while bus_valid=1 and unit 1 is valid -> next cycle bus_valid=0, unit 1 not granted, rr_ptr unchanged. Unit 1 is granted the following cycle.
- Idle and single requester: only unit 2 valid continuously with bus_ready=1 -> granted every cycle, bus_unit=2, rr_ptr stays 3.

Source files
------------

// File: rtl/ppc_types.sv
// Shared PowerPC datapath types: condition/exception flags and the result broadcast record.
package ppc_types;

    localparam int RS_ID_WIDTH_DFLT = 5;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
        logic ov;
        logic ca;
    } cond_exception_t;

    typedef struct packed {
        logic [0:RS_ID_WIDTH_DFLT-1] rs_id;
        logic [0:4]                  reg_addr;
        logic [0:31]                 result;
        cond_exception_t             cr0_xer;
    } result_bus_t;

    // Round-robin successor of idx in a ring of n slots.
    function automatic int rr_wrap_inc(int idx, int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/result_bus_arbiter_rr_priority_select.sv
// Rotating-priority selector: first set request at or after ptr_i, searching modulo N.
module rr_priority_select #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    // Walk the ring from the farthest slot back to ptr_i so the nearest request wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter sharing the single result broadcast bus between execution units,
// with one registered output stage that supports back-to-back grant and consume.
module result_bus_arbiter
    import ppc_types::*;
#(
    parameter  int UNITS       = 4,
    parameter  int RS_ID_WIDTH = RS_ID_WIDTH_DFLT,
    localparam int PTR_WIDTH   = $clog2(UNITS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [UNITS-1:0]                    unit_valid,
    output logic [UNITS-1:0]                    unit_ready,
    input  logic [UNITS-1:0][0:RS_ID_WIDTH-1]   unit_rs_id,
    input  logic [UNITS-1:0][0:4]               unit_reg_addr,
    input  logic [UNITS-1:0][0:31]              unit_result,
    input  cond_exception_t [UNITS-1:0]         unit_cr0_xer,
    output logic                                bus_valid,
    input  logic                                bus_ready,
    output logic [0:RS_ID_WIDTH-1]              bus_rs_id,
    output logic [0:4]                          bus_reg_addr,
    output logic [0:31]                         bus_result,
    output cond_exception_t                     bus_cr0_xer,
    output logic [0:PTR_WIDTH-1]                bus_unit
);

    logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
    result_bus_t          bus_q, bus_d;
    logic                 bus_valid_q, bus_valid_d;
    logic [PTR_WIDTH-1:0] bus_unit_q, bus_unit_d;

    logic [UNITS-1:0]     sel_grant;
    logic [PTR_WIDTH-1:0] sel_idx;
    logic                 sel_any;
    logic                 load_en;
    logic                 grant_en;
    logic                 do_grant;

    rr_priority_select #(.N(UNITS)) u_select (
        .req_i   (unit_valid),
        .ptr_i   (ptr_q),
        .grant_o (sel_grant),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );

    // Grants are only offered when the output register is free or being drained this edge;
    // flush and reset both suppress the handshake so no unit thinks it was accepted.
    always_comb begin
        load_en     = !bus_valid_q || bus_ready;
        grant_en    = rst && !flush && load_en;
        do_grant    = grant_en && sel_any;
        unit_ready  = grant_en ? sel_grant : '0;
        ptr_d       = ptr_q;
        bus_d       = bus_q;
        bus_valid_d = bus_valid_q;
        bus_unit_d  = bus_unit_q;
        if (flush) begin
            bus_valid_d = 1'b0;
        end else if (do_grant) begin
            bus_d.rs_id    = unit_rs_id[sel_idx];
            bus_d.reg_addr = unit_reg_addr[sel_idx];
            bus_d.result   = unit_result[sel_idx];
            bus_d.cr0_xer  = unit_cr0_xer[sel_idx];
            bus_valid_d    = 1'b1;
            bus_unit_d     = sel_idx;
            ptr_d          = PTR_WIDTH'(rr_wrap_inc(int'(sel_idx), UNITS));
        end else if (bus_ready) begin
            bus_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            bus_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_unit_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            bus_q       <= bus_d;
            bus_valid_q <= bus_valid_d;
            bus_unit_q  <= bus_unit_d;
        end
    end

    assign bus_valid    = bus_valid_q;
    assign bus_rs_id    = bus_q.rs_id;
    assign bus_reg_addr = bus_q.reg_addr;
    assign bus_result   = bus_q.result;
    assign bus_cr0_xer  = bus_q.cr0_xer;
    assign bus_unit     = bus_unit_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: directed vector table for the arbitration corner cases,
// then randomized traffic checked against a round-robin reference model.
module tb_result_bus_arbiter;
    import ppc_types::*;

    localparam int UNITS = 4;
    localparam int RSW   = 5;
    localparam int PW    = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush;
    logic                          busReady;
    logic [UNITS-1:0]              unitValid;
    logic [UNITS-1:0]              unitReady;
    logic [UNITS-1:0][0:RSW-1]     unitRsId;
    logic [UNITS-1:0][0:4]         unitRegAddr;
    logic [UNITS-1:0][0:31]        unitResult;
    cond_exception_t [UNITS-1:0]   unitCr;
    logic                          busValid;
    logic [0:RSW-1]                busRsId;
    logic [0:4]                    busRegAddr;
    logic [0:31]                   busResult;
    cond_exception_t               busCr;
    logic [0:PW-1]                 busUnit;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: what the broadcast register should hold, and the ring pointer.
    bit         mValid;
    logic [4:0] mRsId;
    logic [4:0] mAddr;
    logic [31:0] mResult;
    logic [5:0] mCr;
    int         mUnit;
    int         mPtr;

    typedef struct {
        bit               f;
        logic [UNITS-1:0] v;
        bit               r;
        logic [UNITS-1:0] expReady;
        bit               expBv;
        int               expUnit;
        logic [31:0]      expResult;
    } vec_t;

    vec_t table_q[$];
    int   waitCount[UNITS];

    result_bus_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .unit_valid    (unitValid),
        .unit_ready    (unitReady),
        .unit_rs_id    (unitRsId),
        .unit_reg_addr (unitRegAddr),
        .unit_result   (unitResult),
        .unit_cr0_xer  (unitCr),
        .bus_valid     (busValid),
        .bus_ready     (busReady),
        .bus_rs_id     (busRsId),
        .bus_reg_addr  (busRegAddr),
        .bus_result    (busResult),
        .bus_cr0_xer   (busCr),
        .bus_unit      (busUnit)
    );

    always #5 clk = ~clk;

    function automatic int pickUnit(logic [UNITS-1:0] v, int ptr);
        for (int k = 0; k < UNITS; k++) begin
            if (v[(ptr + k) % UNITS]) return (ptr + k) % UNITS;
        end
        return -1;
    endfunction

    function automatic logic [UNITS-1:0] expectedReady();
        int g;
        g = pickUnit(unitValid, mPtr);
        if (!rst || flush || (mValid && !busReady) || g < 0) return '0;
        return UNITS'(1) << g;
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(bit f, logic [UNITS-1:0] v, bit r);
        flush     = f;
        unitValid = v;
        busReady  = r;
    endtask

    task automatic modelReset();
        mValid  = 1'b0;
        mRsId   = '0;
        mAddr   = '0;
        mResult = '0;
        mCr     = '0;
        mUnit   = 0;
        mPtr    = 0;
    endtask

    task automatic modelEdge();
        int g;
        g = pickUnit(unitValid, mPtr);
        if (!rst) begin
            modelReset();
        end else if (flush) begin
            mValid = 1'b0;
        end else if ((!mValid || busReady) && g >= 0) begin
            mValid  = 1'b1;
            mRsId   = unitRsId[g];
            mAddr   = unitRegAddr[g];
            mResult = unitResult[g];
            mCr     = unitCr[g];
            mUnit   = g;
            mPtr    = (g + 1) % UNITS;
        end else if (busReady) begin
            mValid = 1'b0;
        end
    endtask

    task automatic checkBusAgainstModel();
        checkOutput("rand_bus_valid", 32'(busValid), 32'(mValid));
        if (mValid) begin
            checkOutput("rand_bus_rs_id", 32'(busRsId), 32'(mRsId));
            checkOutput("rand_bus_reg_addr", 32'(busRegAddr), 32'(mAddr));
            checkOutput("rand_bus_result", busResult, mResult);
            checkOutput("rand_bus_cr0_xer", 32'(busCr), 32'(mCr));
            checkOutput("rand_bus_unit", 32'(busUnit), 32'(mUnit));
        end
    endtask

    initial begin
        logic [UNITS-1:0] expR;
        logic [UNITS-1:0] grantedLast;

        rst = 1'b0;
        applyStimulus(1'b0, 4'b1111, 1'b1);
        for (int i = 0; i < UNITS; i++) begin
            unitResult[i]  = 32'h100 + 32'(i);
            unitRsId[i]    = RSW'(4 + i);
            unitRegAddr[i] = 5'(16 + i);
            unitCr[i]      = cond_exception_t'(6'(i + 1));
        end
        modelReset();

        // Round robin, sparse wrap, stall, flush, single requester, idle.
        table_q.push_back('{0, 4'b1111, 1, 4'b0001, 1, 0, 32'h100});
        table_q.push_back('{0, 4'b1111, 1, 4'b0010, 1, 1, 32'h101});
        table_q.push_back('{0, 4'b1111, 1, 4'b0100, 1, 2, 32'h102});
        table_q.push_back('{0, 4'b1111, 1, 4'b1000, 1, 3, 32'h103});
        table_q.push_back('{0, 4'b1111, 1, 4'b0001, 1, 0, 32'h100});
        table_q.push_back('{0, 4'b0100, 1, 4'b0100, 1, 2, 32'h102});
        table_q.push_back('{0, 4'b1010, 1, 4'b1000, 1, 3, 32'h103});
        table_q.push_back('{0, 4'b1010, 1, 4'b0010, 1, 1, 32'h101});
        table_q.push_back('{0, 4'b1010, 1, 4'b1000, 1, 3, 32'h103});
        table_q.push_back('{0, 4'b0100, 0, 4'b0000, 1, 3, 32'h103});
        table_q.push_back('{0, 4'b0100, 0, 4'b0000, 1, 3, 32'h103});
        table_q.push_back('{0, 4'b0100, 0, 4'b0000, 1, 3, 32'h103});
        table_q.push_back('{0, 4'b0100, 1, 4'b0100, 1, 2, 32'h102});
        table_q.push_back('{1, 4'b0010, 1, 4'b0000, 0, 0, 32'h0});
        table_q.push_back('{0, 4'b0010, 1, 4'b0010, 1, 1, 32'h101});
        table_q.push_back('{0, 4'b0100, 1, 4'b0100, 1, 2, 32'h102});
        table_q.push_back('{0, 4'b0100, 1, 4'b0100, 1, 2, 32'h102});
        table_q.push_back('{0, 4'b0100, 1, 4'b0100, 1, 2, 32'h102});
        table_q.push_back('{0, 4'b0000, 1, 4'b0000, 0, 0, 32'h0});
        table_q.push_back('{0, 4'b1111, 1, 4'b1000, 1, 3, 32'h103});

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_unit_ready", 32'(unitReady), 32'h0);
        checkOutput("reset_bus_valid", 32'(busValid), 32'h0);
        checkOutput("reset_bus_result", busResult, 32'h0);
        checkOutput("reset_bus_unit", 32'(busUnit), 32'h0);
        checkOutput("reset_bus_rs_id", 32'(busRsId), 32'h0);
        checkOutput("reset_bus_cr0_xer", 32'(busCr), 32'h0);
        rst = 1'b1;

        foreach (table_q[n]) begin
            applyStimulus(table_q[n].f, table_q[n].v, table_q[n].r);
            #1;
            checkOutput($sformatf("vec%0d_unit_ready", n), 32'(unitReady), 32'(table_q[n].expReady));
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput($sformatf("vec%0d_bus_valid", n), 32'(busValid), 32'(table_q[n].expBv));
            if (table_q[n].expBv) begin
                checkOutput($sformatf("vec%0d_bus_unit", n), 32'(busUnit), 32'(table_q[n].expUnit));
                checkOutput($sformatf("vec%0d_bus_result", n), busResult, table_q[n].expResult);
                checkOutput($sformatf("vec%0d_bus_rs_id", n), 32'(busRsId), 32'(4 + table_q[n].expUnit));
                checkOutput($sformatf("vec%0d_bus_reg_addr", n), 32'(busRegAddr), 32'(16 + table_q[n].expUnit));
            end
            @(negedge clk);
        end

        // Random traffic: units keep their payload until accepted, as real producers do.
        grantedLast = '1;
        unitValid   = '0;
        for (int u = 0; u < UNITS; u++) waitCount[u] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int u = 0; u < UNITS; u++) begin
                if (!(unitValid[u] && !grantedLast[u])) begin
                    unitValid[u]   = ($urandom_range(0, 3) != 0);
                    unitRsId[u]    = RSW'($urandom);
                    unitRegAddr[u] = 5'($urandom);
                    unitResult[u]  = $urandom;
                    unitCr[u]      = cond_exception_t'(6'($urandom));
                    waitCount[u]   = 0;
                end
            end
            flush    = ($urandom_range(0, 15) == 0);
            busReady = ($urandom_range(0, 3) != 0);
            #1;
            expR = expectedReady();
            checkOutput("rand_unit_ready", 32'(unitReady), 32'(expR));
            grantedLast = unitReady;
            if (unitReady != '0) begin
                for (int u = 0; u < UNITS; u++) begin
                    if (unitValid[u] && unitReady[u]) begin
                        checkOutput($sformatf("starvation_unit%0d", u), 32'(waitCount[u] < UNITS), 32'h1);
                        waitCount[u] = 0;
                    end else if (unitValid[u]) begin
                        waitCount[u]++;
                    end
                end
            end
            @(posedge clk);
            modelEdge();
            #1;
            checkBusAgainstModel();
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a live broadcast.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        @(posedge clk);
        modelEdge();
        #2;
        checkOutput("pre_async_reset_bus_valid", 32'(busValid), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_bus_valid", 32'(busValid), 32'h0);
        checkOutput("async_reset_unit_ready", 32'(unitReady), 32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("post_reset_unit_ready", 32'(unitReady), 32'(4'b0001));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
